// File: rtl/crypto_wallet_gpio_edge_in.sv
// GPIO input bank: per-bit synchroniser, debounce filter and edge detector, with
// sticky edge capture, interrupt mask and a 4-word Avalon-MM register window.
module crypto_wallet_gpio_edge_in #(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  PRIME_LEN = 3'(SYNC_STAGES + 1);
  localparam logic [1:0]  EDGE_SEL  = 2'(EDGE_TYPE);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out_s;
  logic [WIDTH-1:0] deb_r, deb_s;
  logic [15:0]      cnt_r [WIDTH];
  logic [15:0]      cnt_s [WIDTH];
  logic [2:0]       prime_cnt_r;
  logic             prime_s;
  logic [WIDTH-1:0] update_s, edge_s, clear_s;
  logic [WIDTH-1:0] mask_r, mask_s, capture_r, capture_s;
  logic [31:0]      rdata_s;
  logic             irq_r;

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata_s;
    assign unused_wdata_s = ^writedata[31:WIDTH];
  end

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign prime_s    = (prime_cnt_r != PRIME_LEN);
  assign irq        = irq_r;

  // Metastability chain for the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Debounce filter; during priming the filter tracks the chain without edges.
  always_comb begin
    deb_s    = deb_r;
    update_s = '0;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_s[b] = 16'd0;
      if (prime_s) begin
        deb_s[b] = sync_out_s[b];
      end else if (sync_out_s[b] == deb_r[b]) begin
        cnt_s[b] = 16'd0;
      end else if (cnt_r[b] == DEB_LAST) begin
        deb_s[b]    = sync_out_s[b];
        update_s[b] = 1'b1;
      end else begin
        cnt_s[b] = cnt_r[b] + 16'd1;
      end
    end
  end

  // Edge qualification by direction of the filtered transition.
  always_comb begin
    case (EDGE_SEL)
      2'd0:    edge_s = update_s & ~deb_r & sync_out_s;
      2'd1:    edge_s = update_s & deb_r & ~sync_out_s;
      default: edge_s = update_s;
    endcase
  end

  // Bus-side next state: a capture set beats a same-cycle software clear.
  always_comb begin
    if (write && (address == 2'd3)) clear_s = writedata[WIDTH-1:0];
    else                            clear_s = '0;
    if (write && (address == 2'd2)) mask_s = writedata[WIDTH-1:0];
    else                            mask_s = mask_r;
    capture_s = (capture_r & ~clear_s) | edge_s;
    case (address)
      2'd0:    rdata_s = 32'(deb_r);
      2'd1:    rdata_s = 32'd0;
      2'd2:    rdata_s = 32'(mask_r);
      default: rdata_s = 32'(capture_r);
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt_r <= 3'd0;
      deb_r       <= '0;
      mask_r      <= '0;
      capture_r   <= '0;
      irq_r       <= 1'b0;
      readdata    <= 32'd0;
      for (int b = 0; b < WIDTH; b++) cnt_r[b] <= 16'd0;
    end else begin
      if (prime_s) prime_cnt_r <= prime_cnt_r + 3'd1;
      else         prime_cnt_r <= prime_cnt_r;
      deb_r     <= deb_s;
      mask_r    <= mask_s;
      capture_r <= capture_s;
      irq_r     <= |(capture_s & mask_s);
      readdata  <= rdata_s;
      for (int b = 0; b < WIDTH; b++) cnt_r[b] <= cnt_s[b];
    end
  end

endmodule

// File: tb/tb_crypto_wallet_gpio_edge_in.sv
// Bench for crypto_wallet_gpio_edge_in: four parameterisations share one bus and
// are checked against a cycle-level reference model plus directed expectations.
module tb_crypto_wallet_gpio_edge_in;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        address;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0][31:0]  in_v;
  wire  [3:0][31:0]  rd_dut;
  wire  [3:0]        irq_dut;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one slot per instance.
  logic [31:0] m_hist [4][4];
  logic [31:0] m_deb [4];
  logic [31:0] m_cap [4];
  logic [31:0] m_mask [4];
  logic [31:0] m_rd [4];
  logic        m_irq [4];
  int          m_run [4][32];
  int          m_since [4];

  crypto_wallet_gpio_edge_in #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u_def (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_dut[0]), .in_port(in_v[0][2:0]), .irq(irq_dut[0]));
  crypto_wallet_gpio_edge_in #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_deb (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_dut[1]), .in_port(in_v[1][2:0]), .irq(irq_dut[1]));
  crypto_wallet_gpio_edge_in #(.WIDTH(3), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_dut[2]), .in_port(in_v[2][2:0]), .irq(irq_dut[2]));
  crypto_wallet_gpio_edge_in #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u_wide (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .readdata(rd_dut[3]), .in_port(in_v[3][31:0]), .irq(irq_dut[3]));

  function automatic int mw(input int k);
    if (k == 3) return 32; else return 3;
  endfunction
  function automatic int ms(input int k);
    if (k == 2) return 3; else return 2;
  endfunction
  function automatic int md(input int k);
    if (k == 1) return 4; else return 1;
  endfunction
  function automatic int me(input int k);
    case (k)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction
  function automatic logic [31:0] wmask(input int k);
    if (mw(k) == 32) return 32'hFFFF_FFFF;
    else             return (32'h1 << mw(k)) - 32'h1;
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_step();
    logic [31:0] so, edges, clr, msk;
    for (int k = 0; k < 4; k++) begin
      msk = wmask(k);
      if (reset) begin
        for (int i = 0; i < 4; i++) m_hist[k][i] = 32'h0;
        m_deb[k] = 32'h0; m_cap[k] = 32'h0; m_mask[k] = 32'h0; m_rd[k] = 32'h0;
        m_irq[k] = 1'b0; m_since[k] = 0;
        for (int b = 0; b < 32; b++) m_run[k][b] = 0;
      end else begin
        so = m_hist[k][ms(k)-1];
        case (address)
          2'd0:    m_rd[k] = m_deb[k];
          2'd1:    m_rd[k] = 32'h0;
          2'd2:    m_rd[k] = m_mask[k];
          default: m_rd[k] = m_cap[k];
        endcase
        for (int i = 3; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = in_v[k] & msk;
        edges = 32'h0;
        if (m_since[k] < ms(k) + 1) begin
          m_deb[k] = so;
          m_since[k]++;
          for (int b = 0; b < 32; b++) m_run[k][b] = 0;
        end else begin
          for (int b = 0; b < mw(k); b++) begin
            if (so[b] == m_deb[k][b]) m_run[k][b] = 0;
            else begin
              m_run[k][b]++;
              if (m_run[k][b] == md(k)) begin
                m_run[k][b] = 0;
                if (me(k) == 2 || (me(k) == 0 && so[b]) || (me(k) == 1 && !so[b])) edges[b] = 1'b1;
                m_deb[k][b] = so[b];
              end
            end
          end
        end
        clr = (write && address == 2'd3) ? (writedata & msk) : 32'h0;
        m_cap[k] = (m_cap[k] & ~clr) | edges;
        if (write && address == 2'd2) m_mask[k] = writedata & msk;
        m_irq[k] = |(m_cap[k] & m_mask[k]);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    tick();
    write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rd_dut[k] !== 32'h0 || irq_dut[k] !== 1'b0)
        $display("FAIL reset_state inst%0d: readdata=%h irq=%b required 0/0", k, rd_dut[k], irq_dut[k]);
      else n_pass++;
    end
    reset = 1'b0; address = 2'd0;
    repeat (6) tick();
    n_checks++;
    if (rd_dut[0] !== 32'h5) $display("FAIL prime_deb inst0: got %h required 00000005", rd_dut[0]);
    else n_pass++;
    n_checks++;
    if (rd_dut[2] !== 32'h4) $display("FAIL prime_deb inst2: got %h required 00000004", rd_dut[2]);
    else n_pass++;
    address = 2'd3;
    tick();
    n_checks++;
    if (rd_dut[0] !== 32'h0 || irq_dut !== 4'b0000)
      $display("FAIL prime_no_capture: cap=%h irq=%b required 0/0000", rd_dut[0], irq_dut);
    else n_pass++;
  endtask

  task automatic test_edge_latency();
    bus_write(2'd2, 32'h7);
    address = 2'd3;
    in_v[0] = 32'h7;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (irq_dut[0] !== (i == 3)) $display("FAIL rise_latency cycle %0d: irq=%b required %b", i, irq_dut[0], (i == 3));
      else n_pass++;
    end
    tick();
    n_checks++;
    if (rd_dut[0] !== 32'h2) $display("FAIL rise_capture: got %h required 00000002", rd_dut[0]);
    else n_pass++;
    bus_write(2'd3, 32'h2);
    n_checks++;
    if (irq_dut[0] !== 1'b0) $display("FAIL w1c_irq: irq=%b required 0", irq_dut[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_dut[0] !== 32'h0) $display("FAIL w1c_cap: got %h required 00000000", rd_dut[0]);
    else n_pass++;
  endtask

  task automatic test_debounce();
    address = 2'd0;
    in_v[1][0] = 1'b1;
    repeat (3) tick();
    in_v[1][0] = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (rd_dut[1] !== 32'h0) $display("FAIL glitch_deb: got %h required 00000000", rd_dut[1]);
    else n_pass++;
    address = 2'd3;
    tick();
    n_checks++;
    if (rd_dut[1] !== 32'h0 || irq_dut[1] !== 1'b0)
      $display("FAIL glitch_cap: cap=%h irq=%b required 0/0", rd_dut[1], irq_dut[1]);
    else n_pass++;
    address = 2'd0;
    in_v[1][0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (irq_dut[1] !== (i == 6) || rd_dut[1] !== 32'h0)
        $display("FAIL debounce_hold cycle %0d: irq=%b deb=%h required %b/0", i, irq_dut[1], rd_dut[1], (i == 6));
      else n_pass++;
    end
    tick();
    n_checks++;
    if (rd_dut[1] !== 32'h1) $display("FAIL debounce_deb: got %h required 00000001", rd_dut[1]);
    else n_pass++;
  endtask

  task automatic test_edge_types();
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    in_v[2][2] = 1'b0; in_v[1][2] = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (rd_dut[2] !== 32'h4 || rd_dut[1] !== 32'h4)
      $display("FAIL edge_phase1: fall_inst=%h any_inst=%h required 4/4", rd_dut[2], rd_dut[1]);
    else n_pass++;
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    in_v[2][2] = 1'b1; in_v[1][2] = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (rd_dut[2] !== 32'h0 || rd_dut[1] !== 32'h4)
      $display("FAIL edge_phase2: fall_inst=%h any_inst=%h required 0/4", rd_dut[2], rd_dut[1]);
    else n_pass++;
    bus_write(2'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_set_wins();
    address = 2'd3;
    in_v[0][0] = 1'b0;
    repeat (5) tick();
    in_v[0][0] = 1'b1;
    tick(); tick();
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (irq_dut[0] !== 1'b1) $display("FAIL set_wins_irq: irq=%b required 1", irq_dut[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_dut[0] !== 32'h1) $display("FAIL set_wins_cap: got %h required 00000001", rd_dut[0]);
    else n_pass++;
  endtask

  task automatic test_wide();
    bus_write(2'd2, 32'h8000_0000);
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    in_v[3][31] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (rd_dut[3] !== 32'h8000_0000 || irq_dut[3] !== 1'b1)
      $display("FAIL wide_bit31: cap=%h irq=%b required 80000000/1", rd_dut[3], irq_dut[3]);
    else n_pass++;
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    in_v[3][0] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (rd_dut[3] !== 32'h1 || irq_dut[3] !== 1'b0)
      $display("FAIL wide_bit0: cap=%h irq=%b required 00000001/0", rd_dut[3], irq_dut[3]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      address   = 2'($urandom_range(0, 3));
      write     = ($urandom_range(0, 5) == 0);
      writedata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      for (int k = 0; k < 4; k++) in_v[k] = in_v[k] ^ ($urandom() & $urandom() & $urandom());
      tick();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rd_dut[k] !== m_rd[k])
          $display("FAIL random_readdata inst%0d cycle %0d: got %h required %h", k, c, rd_dut[k], m_rd[k]);
        else n_pass++;
        n_checks++;
        if (irq_dut[k] !== m_irq[k])
          $display("FAIL random_irq inst%0d cycle %0d: got %b required %b", k, c, irq_dut[k], m_irq[k]);
        else n_pass++;
      end
    end
    reset = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; write = 1'b0; writedata = 32'h0;
    in_v = '0;
    in_v[0] = 32'h5;
    in_v[2] = 32'h4;
    test_reset();
    test_edge_latency();
    test_debounce();
    test_edge_types();
    test_set_wins();
    test_wide();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crypto_wallet_gpio_edge_in.md
CRYPTO_WALLET_GPIO_EDGE_IN -- requirements
Module: crypto_wallet_gpio_edge_in

Interface
REQ-001 SHALL have parameter WIDTH, default 3: input port width, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1: stable cycles required before the filtered value updates, legal range 1..65535.
REQ-004 SHALL have parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-008 SHALL have port write, input, 1 bit: active-high write strobe.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 SHALL have port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-013 SHALL pass each in_port bit through a SYNC_STAGES-deep flop chain, giving sync_out.
REQ-014 SHALL keep one per-bit debounce counter, 16 bits wide, and a per-bit filtered value deb.
REQ-015 SHALL clear a bit's counter in every cycle in which sync_out equals deb.
REQ-016 SHALL increment the counter while sync_out differs from deb, and SHALL load sync_out into deb (clearing the counter) on the cycle the counter equals DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1, deb follows sync_out one cycle later.
REQ-017 SHALL restart the count from zero, with no update to deb, when an input glitch returns to the deb value before the count completes.
REQ-018 SHALL raise a per-bit edge pulse in the cycle deb is updated, qualified by EDGE_TYPE:
- rising: old deb 0, new 1
- falling: old deb 1, new 0
- any: either direction.
REQ-019 SHALL provide a prime phase of SYNC_STAGES+1 cycles after reset deasserts. During it, deb loads sync_out directly every cycle and edge pulses are suppressed, so no spurious capture occurs for inputs held static across reset.
REQ-020 SHALL set the edgecapture bit on an edge pulse; the bit stays set until cleared by software.
REQ-021 SHALL clear the addressed edgecapture bits when writedata bit is 1 on a write to address 3; bits written 0 are unaffected.
REQ-022 SHALL leave an edgecapture bit set when an edge pulse and a write-1-to-clear hit the same bit in the same cycle (set wins).
REQ-023 SHALL load interruptmask[WIDTH-1:0] from writedata on a write to address 2.
REQ-024 SHALL ignore writes to addresses 0 and 1.
REQ-025 SHALL update readdata every cycle from the address present at the rising edge (1-cycle read latency), zero-extended above WIDTH:
- address 0: deb
- address 1: 0
- address 2: interruptmask
- address 3: edgecapture.
REQ-026 SHALL drive irq from registered state as OR over (edgecapture AND interruptmask), with no combinational path from bus inputs.
REQ-027 SHALL give an in_port step held stable a total latency to deb of SYNC_STAGES+DEBOUNCE_CYCLES clk cycles, and to edgecapture the same.

Reset
REQ-028 SHALL, while reset is high at a rising clk edge, clear all of the following to 0: sync chain, deb, counters, interruptmask, edgecapture, readdata. irq SHALL be 0 and the prime phase SHALL restart.
REQ-029 SHALL, when reset is asserted mid-debounce or mid-prime, abandon the operation with no edgecapture update.

Verification
REQ-030 Defaults, reset released with in_port=3'b101 held -> after prime, address 0 reads 0x5; edgecapture reads 0x0; irq=0.
REQ-031 Defaults, mask=0x7, in_port bit1 0->1 -> edgecapture=0x2 exactly SYNC_STAGES+1=3 cycles later; irq=1; write 0x2 to address 3 -> edgecapture=0, irq=0 next cycle.
REQ-032 DEBOUNCE_CYCLES=4: bit0 high pulse of 3 cycles -> deb and edgecapture unchanged; held 4 cycles -> deb bit0=1 and edgecapture bit0=1 at cycle SYNC_STAGES+4.
REQ-033 EDGE_TYPE=1: bit2 rise -> no capture; bit2 fall -> edgecapture=0x4; EDGE_TYPE=2 -> both captured.
REQ-034 Clear write of 0x1 coincident with a new bit0 edge pulse -> edgecapture bit0 remains 1.
REQ-035 WIDTH=32, mask=0x8000_0000, edge on bit31 -> readdata at address 3 = 0x8000_0000 and irq=1; edge on bit0 only -> irq=0.
